// File: rtl/canny_window_gen_if.sv
// Raster pixel stream into the canny window generator.
// Valid-qualified, no backpressure.
interface canny_window_gen_if #(
  parameter int PIX_W = 16
);
  logic             pix_valid;
  logic             pix_sof;
  logic [PIX_W-1:0] pix_in;

  modport master (
    output pix_valid,
    output pix_sof,
    output pix_in
  );

  modport slave (
    input pix_valid,
    input pix_sof,
    input pix_in
  );
endinterface

// File: rtl/canny_window_gen.sv
// Raster stream to 3x3 window generator feeding the canny core.
// Optional CANNY_WIN_COORD_EN adds window-centre outputs win_x/win_y.
module canny_window_gen #(
  parameter int PIX_W      = 16,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  canny_window_gen_if.slave     pix,
  output logic [PIX_W-1:0]      im11,
  output logic [PIX_W-1:0]      im12,
  output logic [PIX_W-1:0]      im13,
  output logic [PIX_W-1:0]      im21,
  output logic [PIX_W-1:0]      im22,
  output logic [PIX_W-1:0]      im23,
  output logic [PIX_W-1:0]      im31,
  output logic [PIX_W-1:0]      im32,
  output logic [PIX_W-1:0]      im33,
  output logic                  start,
  output logic                  frame_done
`ifdef CANNY_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  logic [1:0]       rst_pipe;
  logic             rst_sync;

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;
  logic [XW-1:0]    x_nxt;
  logic [YW-1:0]    y_nxt;
  logic             x_last;
  logic             y_last;
  logic             win_hit;
  logic             last_hit;

  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  // Reset asserts at once, releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_sync = rst_pipe[1];

  // sof forces the accepted pixel to (0,0).
  always_comb begin
    cur_x = x;
    cur_y = y;
    if (pix.pix_sof) begin
      cur_x = '0;
      cur_y = '0;
    end
  end

  assign x_last   = (cur_x == X_LAST);
  assign y_last   = (cur_y == Y_LAST);
  assign win_hit  = pix.pix_valid
                 && (cur_x >= X_TWO)
                 && (cur_y >= Y_TWO);
  assign last_hit = pix.pix_valid && x_last && y_last;

  assign lb0_rd = lb0[cur_x];
  assign lb1_rd = lb1[cur_x];

  // Raster position following the accepted pixel.
  always_comb begin
    x_nxt = cur_x;
    y_nxt = cur_y;
    unique case (1'b1)
      !x_last: begin
        x_nxt = cur_x + XW'(1);
      end
      x_last && y_last: begin
        x_nxt = '0;
        y_nxt = '0;
      end
      x_last && !y_last: begin
        x_nxt = '0;
        y_nxt = cur_y + YW'(1);
      end
      default: begin
        x_nxt = cur_x;
        y_nxt = cur_y;
      end
    endcase
  end

  // Position counters advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      x <= '0;
      y <= '0;
    end else if (pix.pix_valid) begin
      x <= x_nxt;
      y <= y_nxt;
    end
  end

  // Line buffers: lb0 holds row y-1, lb1 row y-2; never cleared.
  always_ff @(posedge clk) begin
    if (pix.pix_valid) begin
      lb1[cur_x] <= lb0_rd;
      lb0[cur_x] <= pix.pix_in;
    end
  end

  // 3x3 window shifts left, new column enters at col 3.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      {im11, im12, im13} <= '0;
      {im21, im22, im23} <= '0;
      {im31, im32, im33} <= '0;
    end else if (pix.pix_valid) begin
      im11 <= im12;
      im12 <= im13;
      im13 <= lb1_rd;
      im21 <= im22;
      im22 <= im23;
      im23 <= lb0_rd;
      im31 <= im32;
      im32 <= im33;
      im33 <= pix.pix_in;
    end
  end

  // Strobes for a complete window and for the frame's last pixel.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      start      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      start      <= win_hit;
      frame_done <= last_hit;
    end
  end

`ifdef CANNY_WIN_COORD_EN
  // Window centre sits one column and one row behind the pixel.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      win_x <= '0;
      win_y <= '0;
    end else if (win_hit) begin
      win_x <= cur_x - XW'(1);
      win_y <= cur_y - YW'(1);
    end
  end
`endif

endmodule
